fetch_unit: RTL and testbench

Instruction fetch front end for the RV32I core: owns the program counter, issues word requests to instruction memory over a req/gnt/rvalid handshake, buffers returned instructions in a 2-entry queue, and presents them to decode with a valid/ready handshake. Sits directly upstream of the core's decoder/sign-extender input. It replaces the direct test feed of the instruction word. Taken branches and jumps arrive as a redirect that flushes in-flight fetches.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int          FETCH_BUF_DEPTH = 2;
  localparam logic [31:0] PC_STEP         = 32'd4;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched instructions. Flush wins over push/pop.
// The head outputs keep showing the last presented entry while empty.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  fetch_entry_t last_head;
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;
  logic [1:0]   count_nxt;

  // Qualify push/pop against occupancy and compute the next count.
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'(FETCH_BUF_DEPTH)) || do_pop);
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 2'd1;
    else if (!do_push && do_pop) count_nxt = count - 2'd1;
  end

  // Storage, pointers, occupancy and the held-head copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) mem[i] <= '0;
      last_head <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (count != 2'd0) last_head <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_entry;
          wr_ptr      <= ~wr_ptr;
        end
        if (do_pop) rd_ptr <= ~rd_ptr;
        count <= count_nxt;
      end
    end
  end

  // Head comes from storage while occupied, otherwise the last value shown.
  always_comb begin
    head = last_head;
    if (count != 2'd0) head = mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding memory handshake,
// redirect/flush handling and a 2-entry buffer towards decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        misaligned
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  pc;
  logic [31:0]  fetched_pc;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         granted;
  logic         push;
  logic         pop;

  assign granted    = imem_req && imem_gnt;
  assign push       = (state == WAIT) && imem_rvalid && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign push_entry = '{pc: fetched_pc, inst: imem_rdata};

  assign imem_addr  = pc;
  assign inst_valid = (count != 2'd0);
  assign inst_out   = head.inst;
  assign inst_pc    = head.pc;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  // Next state; a redirect turns any in-flight request into one to drain.
  always_comb begin
    state_nxt = state;
    case (state)
      REQ: begin
        if (granted) state_nxt = redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        if (imem_rvalid)   state_nxt = REQ;
        else if (redirect) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  // FSM outputs; the credit check keeps count + outstanding within the buffer.
  always_comb begin
    imem_req = 1'b0;
    if (!rst && (state == REQ) && (count < 2'(FETCH_BUF_DEPTH))) imem_req = 1'b1;
  end

  // PC, address-at-grant latch and misaligned-redirect pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      fetched_pc <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
      if (granted) fetched_pc <= pc;
      if (redirect)     pc <= align_word(redirect_pc);
      else if (granted) pc <= pc + PC_STEP;
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance at the default reset PC and
// a second instance starting at the top of the address space.
module tb_fetch_unit;

  localparam logic [31:0] R1 = 32'h0050_0093;
  localparam logic [31:0] R2 = 32'h00a0_0113;
  localparam logic [31:0] R3 = 32'h0020_8193;
  localparam logic [31:0] R4 = 32'h0011_0213;
  localparam logic [31:0] R5 = 32'h0041_8293;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_gnt, imem_rvalid, redirect;
  logic        inst_valid, inst_ready, misaligned;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_out, inst_pc;

  logic        b_rst, b_req, b_gnt, b_rvalid, b_redirect;
  logic        b_iv, b_ready, b_mis;
  logic [31:0] b_addr, b_rdata, b_rpc, b_iout, b_ipc;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .misaligned(misaligned)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk(clk), .rst(b_rst), .imem_req(b_req), .imem_addr(b_addr),
    .imem_gnt(b_gnt), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .redirect(b_redirect), .redirect_pc(b_rpc), .inst_valid(b_iv),
    .inst_ready(b_ready), .inst_out(b_iout), .inst_pc(b_ipc),
    .misaligned(b_mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    b_rst = 1'b1; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
    b_redirect = 1'b0; b_rpc = '0; b_ready = 1'b0;

    cyc();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_out", inst_out, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_mis", misaligned, 0);

    rst = 1'b0;
    #1;
    chk("c0_req", imem_req, 1);
    chk("c0_addr", imem_addr, 32'h0);
    cyc();
    chk("c1_req", imem_req, 0);
    chk("c1_addr", imem_addr, 32'h4);
    imem_rvalid = 1'b1; imem_rdata = R1;
    cyc();
    chk("c2_valid", inst_valid, 1);
    chk("c2_pc", inst_pc, 32'h0);
    chk("c2_out", inst_out, R1);
    chk("c2_req", imem_req, 1);
    chk("c2_addr", imem_addr, 32'h4);
    imem_rvalid = 1'b0;
    cyc();
    imem_rvalid = 1'b1; imem_rdata = R2;
    cyc();
    chk("full_req", imem_req, 0);
    chk("full_addr", imem_addr, 32'h8);
    chk("full_head_pc", inst_pc, 32'h0);
    imem_rvalid = 1'b0;
    cyc();
    chk("full_req_hold", imem_req, 0);
    chk("full_valid", inst_valid, 1);
    inst_ready = 1'b1;
    cyc();
    chk("pop1_pc", inst_pc, 32'h4);
    chk("pop1_out", inst_out, R2);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h8);
    cyc();
    chk("empty_valid", inst_valid, 0);
    chk("empty_hold_out", inst_out, R2);
    chk("empty_hold_pc", inst_pc, 32'h4);
    inst_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = R3;
    cyc();
    chk("c8_valid", inst_valid, 1);
    chk("c8_pc", inst_pc, 32'h8);
    chk("c8_out", inst_out, R3);
    chk("c8_addr", imem_addr, 32'hC);
    imem_rvalid = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 32'hC);
      if (i == 2) imem_gnt = 1'b1;
      cyc();
    end
    chk("gnt_req", imem_req, 0);
    chk("gnt_addr", imem_addr, 32'h10);
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    chk("drain_req", imem_req, 0);
    chk("drain_addr", imem_addr, 32'h100);
    chk("drain_mis", misaligned, 0);
    imem_rvalid = 1'b1; imem_rdata = STALE;
    cyc();
    imem_rvalid = 1'b0;
    chk("stale_valid", inst_valid, 0);
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = R4;
    chk("redir_addr2", imem_addr, 32'h104);
    cyc();
    imem_rvalid = 1'b0;
    chk("redir_valid", inst_valid, 1);
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_out", inst_out, R4);
    redirect = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect = 1'b0;
    chk("mis_pulse", misaligned, 1);
    chk("mis_flush", inst_valid, 0);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_req", imem_req, 1);
    cyc();
    chk("mis_clear", misaligned, 0);
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0; imem_gnt = 1'b0;
    chk("rg_req", imem_req, 0);
    chk("rg_addr", imem_addr, 32'h200);
    imem_rvalid = 1'b1; imem_rdata = STALE;
    cyc();
    imem_rvalid = 1'b0;
    chk("rg_req2", imem_req, 1);
    chk("rg_valid", inst_valid, 0);
    chk("rg_no_stale", inst_out, R4);

    b_gnt = 1'b1; b_rst = 1'b0;
    #1;
    chk("top_addr0", b_addr, 32'hFFFF_FFFC);
    chk("top_req0", b_req, 1);
    cyc();
    chk("wrap_addr", b_addr, 32'h0);
    chk("wrap_req", b_req, 0);
    b_rvalid = 1'b1; b_rdata = R5;
    cyc();
    b_rvalid = 1'b0;
    chk("top_valid", b_iv, 1);
    chk("top_pc", b_ipc, 32'hFFFF_FFFC);
    chk("top_out", b_iout, R5);
    chk("second_addr", b_addr, 32'h0);
    chk("second_req", b_req, 1);
    cyc();
    #2;
    b_rst = 1'b1;
    #1;
    chk("arst_req", b_req, 0);
    chk("arst_valid", b_iv, 0);
    chk("arst_addr", b_addr, 32'hFFFF_FFFC);
    cyc();
    b_rst = 1'b0; b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = STALE;
    cyc();
    b_rvalid = 1'b0;
    chk("late_valid", b_iv, 0);
    chk("late_req", b_req, 1);
    chk("late_addr", b_addr, 32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
